// File: rtl/period_meter.sv
// Period meter: measures rising-edge-to-rising-edge period and high time of an
// asynchronous input in base-clock cycles, and flags an input that stops toggling.
module period_meter #(
  parameter int CNT_W   = 32,
  parameter int TIMEOUT = 1000000
) (
  input  logic             clk_in,
  input  logic             rst,
  input  logic             sig_in,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] high_time,
  output logic             period_vld,
  output logic             stalled
);

  typedef enum logic {
    IDLE = 1'b0,
    MEAS = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

  state_t           state, state_next;
  logic             sync_meta;
  logic             sig_s;
  logic             sig_d;
  logic             rise;
  logic [CNT_W-1:0] pcnt, pcnt_next;
  logic [CNT_W-1:0] hcnt, hcnt_next;
  logic [CNT_W-1:0] period_next;
  logic [CNT_W-1:0] high_time_next;
  logic             period_vld_next;
  logic             stalled_next;

  // Two-flop synchroniser plus a delayed copy for rising-edge detection.
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      sync_meta <= 1'b0;
      sig_s     <= 1'b0;
      sig_d     <= 1'b0;
    end else begin
      sync_meta <= sig_in;
      sig_s     <= sync_meta;
      sig_d     <= sig_s;
    end
  end

  assign rise = sig_s & ~sig_d;

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next      = state;
    pcnt_next       = pcnt;
    hcnt_next       = hcnt;
    period_next     = period;
    high_time_next  = high_time;
    period_vld_next = 1'b0;
    stalled_next    = stalled;

    unique case (state)
      IDLE: begin
        pcnt_next = '0;
        hcnt_next = '0;
        // The first edge only opens a measurement window; nothing to report yet.
        if (rise) begin
          state_next   = MEAS;
          pcnt_next    = CNT_ONE;
          hcnt_next    = CNT_ONE;
          stalled_next = 1'b0;
        end
      end

      MEAS: begin
        if (rise) begin
          period_next     = pcnt;
          high_time_next  = hcnt;
          period_vld_next = 1'b1;
          pcnt_next       = CNT_ONE;
          hcnt_next       = CNT_ONE;
          stalled_next    = 1'b0;
        end else if (pcnt == TIMEOUT_CNT) begin
          // Give up on this window; last good result stays on the outputs.
          state_next   = IDLE;
          pcnt_next    = '0;
          hcnt_next    = '0;
          stalled_next = 1'b1;
        end else begin
          pcnt_next = pcnt + CNT_ONE;
          hcnt_next = hcnt + {{(CNT_W-1){1'b0}}, sig_s};
        end
      end

      default: begin
        state_next = IDLE;
        pcnt_next  = '0;
        hcnt_next  = '0;
      end
    endcase
  end

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      pcnt       <= '0;
      hcnt       <= '0;
      period     <= '0;
      high_time  <= '0;
      period_vld <= 1'b0;
      stalled    <= 1'b0;
    end else begin
      pcnt       <= pcnt_next;
      hcnt       <= hcnt_next;
      period     <= period_next;
      high_time  <= high_time_next;
      period_vld <= period_vld_next;
      stalled    <= stalled_next;
    end
  end

endmodule
